// File: rtl/regstatus_sched_pkg.sv
// Shared constants, state encoding and tag helpers for the register-status write-port scheduler.
package regstatus_sched_pkg;

    localparam int NREG  = 32;
    localparam int IDXW  = 5;
    localparam int TAGW  = 6;
    localparam int CNTW  = 2;

    localparam logic [TAGW-1:0] INVALID   = 6'b010000;
    localparam logic [TAGW-1:0] TAG_LIMIT = 6'd16;
    localparam logic [IDXW-1:0] LAST_IDX  = 5'd31;
    localparam logic [IDXW-1:0] ZERO_IDX  = 5'd0;
    localparam logic [CNTW-1:0] STARVE    = 2'd2;
    localparam logic [CNTW-1:0] CNT_MAX   = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } sched_state_e;

    // Tags at or above TAG_LIMIT (including INVALID itself) never name a ROB entry.
    function automatic logic tag_legal(input logic [TAGW-1:0] tag);
        return (tag < TAG_LIMIT);
    endfunction

    // x0 is hard-wired to "no producer" and never receives a write.
    function automatic logic idx_writable(input logic [IDXW-1:0] idx);
        return (idx != ZERO_IDX);
    endfunction

endpackage

// File: rtl/regstatus_sched.sv
// Arbitrates the single rename-table write port between dispatch and commit and
// sequences a full-table invalidate after a mispredict flush.
module regstatus_sched
    import regstatus_sched_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            disp_valid,
    input  logic [IDXW-1:0] disp_rd,
    input  logic [TAGW-1:0] disp_tag,
    output logic            disp_ready,
    input  logic            cmt_valid,
    input  logic [IDXW-1:0] cmt_rd,
    input  logic [TAGW-1:0] cmt_tag,
    output logic            cmt_ready,
    input  logic            flush,
    output logic            flush_busy,
    output logic [IDXW-1:0] st_ridx,
    input  logic [TAGW-1:0] st_rdata,
    output logic            st_we,
    output logic [IDXW-1:0] st_idx,
    output logic [TAGW-1:0] st_data
);

    sched_state_e    state_r;
    logic [IDXW-1:0] flush_idx_r;
    logic [CNTW-1:0] starve_cnt_r;

    logic [TAGW-1:0] eff_tag_s;
    logic            own_s;
    logic            disp_need_s;
    logic            cmt_need_s;
    logic            wr_en_s;
    logic [IDXW-1:0] wr_idx_s;
    logic [TAGW-1:0] wr_data_s;
    logic            starve_inc_s;
    logic            cmt_accept_s;

    assign st_ridx = cmt_rd;

    // Ownership check, bypassing the write that is on its way into the table this cycle.
    always_comb begin
        eff_tag_s = st_rdata;
        if (st_we && (st_idx == cmt_rd)) begin
            eff_tag_s = st_data;
        end else begin
            eff_tag_s = st_rdata;
        end
        own_s       = (eff_tag_s == cmt_tag);
        disp_need_s = disp_valid && idx_writable(disp_rd) && tag_legal(disp_tag);
        cmt_need_s  = cmt_valid && own_s && idx_writable(cmt_rd) && tag_legal(cmt_tag);
    end

    // IDLE arbitration: decide acceptance and which single write (if any) goes out.
    always_comb begin
        disp_ready   = 1'b0;
        cmt_ready    = 1'b0;
        wr_en_s      = 1'b0;
        wr_idx_s     = ZERO_IDX;
        wr_data_s    = INVALID;
        starve_inc_s = 1'b0;
        if ((state_r == ST_IDLE) && !flush) begin
            if (disp_need_s && cmt_need_s && (disp_rd != cmt_rd)) begin
                // Genuine port conflict: commit only wins once it has been starved long enough.
                if (starve_cnt_r >= STARVE) begin
                    cmt_ready = 1'b1;
                    wr_en_s   = 1'b1;
                    wr_idx_s  = cmt_rd;
                    wr_data_s = INVALID;
                end else begin
                    disp_ready   = 1'b1;
                    wr_en_s      = 1'b1;
                    wr_idx_s     = disp_rd;
                    wr_data_s    = disp_tag;
                    starve_inc_s = 1'b1;
                end
            end else begin
                disp_ready = disp_valid;
                cmt_ready  = cmt_valid;
                // A dispatch to the same rd supersedes the commit release.
                if (disp_need_s) begin
                    wr_en_s   = 1'b1;
                    wr_idx_s  = disp_rd;
                    wr_data_s = disp_tag;
                end else if (cmt_need_s) begin
                    wr_en_s   = 1'b1;
                    wr_idx_s  = cmt_rd;
                    wr_data_s = INVALID;
                end else begin
                    wr_en_s = 1'b0;
                end
            end
        end else begin
            disp_ready = 1'b0;
            cmt_ready  = 1'b0;
        end
        cmt_accept_s = cmt_valid && cmt_ready;
    end

    // Scheduler FSM with registered write port, flush index and starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            flush_idx_r  <= ZERO_IDX;
            starve_cnt_r <= 2'd0;
            flush_busy   <= 1'b0;
            st_we        <= 1'b0;
            st_idx       <= ZERO_IDX;
            st_data      <= INVALID;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (flush) begin
                        state_r     <= ST_FLUSH;
                        flush_idx_r <= ZERO_IDX;
                        flush_busy  <= 1'b1;
                        st_we       <= 1'b0;
                    end else begin
                        st_we <= wr_en_s;
                        if (wr_en_s) begin
                            st_idx  <= wr_idx_s;
                            st_data <= wr_data_s;
                        end else begin
                            st_idx  <= st_idx;
                            st_data <= st_data;
                        end
                        if (cmt_accept_s) begin
                            starve_cnt_r <= 2'd0;
                        end else if (starve_inc_s && (starve_cnt_r != CNT_MAX)) begin
                            starve_cnt_r <= starve_cnt_r + 2'd1;
                        end else begin
                            starve_cnt_r <= starve_cnt_r;
                        end
                    end
                end
                ST_FLUSH: begin
                    st_we   <= 1'b1;
                    st_idx  <= flush_idx_r;
                    st_data <= INVALID;
                    if (flush_idx_r == LAST_IDX) begin
                        state_r      <= ST_IDLE;
                        flush_idx_r  <= ZERO_IDX;
                        flush_busy   <= 1'b0;
                        starve_cnt_r <= 2'd0;
                    end else begin
                        flush_idx_r <= flush_idx_r + 5'd1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    flush_idx_r <= ZERO_IDX;
                    flush_busy  <= 1'b0;
                    st_we       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regstatus_sched.sv
// Directed self-checking bench for regstatus_sched with a behavioural rename table model.
module tb_regstatus_sched;
    import regstatus_sched_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            disp_valid;
    logic [IDXW-1:0] disp_rd;
    logic [TAGW-1:0] disp_tag;
    logic            disp_ready;
    logic            cmt_valid;
    logic [IDXW-1:0] cmt_rd;
    logic [TAGW-1:0] cmt_tag;
    logic            cmt_ready;
    logic            flush;
    logic            flush_busy;
    logic [IDXW-1:0] st_ridx;
    logic [TAGW-1:0] st_rdata;
    logic            st_we;
    logic [IDXW-1:0] st_idx;
    logic [TAGW-1:0] st_data;

    logic [TAGW-1:0] tbl [NREG];
    int checks = 0;
    int errors = 0;

    regstatus_sched dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_rd(disp_rd), .disp_tag(disp_tag), .disp_ready(disp_ready),
        .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag), .cmt_ready(cmt_ready),
        .flush(flush), .flush_busy(flush_busy),
        .st_ridx(st_ridx), .st_rdata(st_rdata),
        .st_we(st_we), .st_idx(st_idx), .st_data(st_data)
    );

    always #5 clk = ~clk;

    assign st_rdata = tbl[st_ridx];

    // External table: cleared while reset is held, otherwise takes the scheduled write.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) tbl[i] <= INVALID;
        end else if (st_we) begin
            tbl[st_idx] <= st_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        disp_valid = 1'b0; disp_rd = 5'd0; disp_tag = 6'd0;
        cmt_valid  = 1'b0; cmt_rd  = 5'd0; cmt_tag  = 6'd0;
        flush      = 1'b0;
    endtask

    task automatic set_disp(input logic [4:0] rd, input logic [5:0] tag);
        disp_valid = 1'b1; disp_rd = rd; disp_tag = tag;
    endtask

    task automatic set_cmt(input logic [4:0] rd, input logic [5:0] tag);
        cmt_valid = 1'b1; cmt_rd = rd; cmt_tag = tag;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        tick(); tick();
        rst = 1'b0;
        #1;
        // 1: reset / idle state
        chk("rst_we", st_we, 1'b0);
        chk("rst_data", st_data, 6'h10);
        chk("rst_idx", st_idx, 5'd0);
        chk("rst_busy", flush_busy, 1'b0);
        chk("rst_drdy", disp_ready, 1'b0);
        chk("rst_crdy", cmt_ready, 1'b0);

        // 2: plain dispatch rd5 <- 3
        tick();
        set_disp(5'd5, 6'd3); #1;
        chk("d_rdy", disp_ready, 1'b1);
        tick(); idle_inputs();
        chk("d_we", st_we, 1'b1);
        chk("d_idx", st_idx, 5'd5);
        chk("d_data", st_data, 6'd3);

        // 3: owning commit (via bypass) releases rd5, stale commit writes nothing
        set_cmt(5'd5, 6'd3); #1;
        chk("c_rdy", cmt_ready, 1'b1);
        chk("c_ridx", st_ridx, 5'd5);
        tick(); idle_inputs();
        chk("c_we", st_we, 1'b1);
        chk("c_idx", st_idx, 5'd5);
        chk("c_data", st_data, 6'h10);
        set_cmt(5'd5, 6'd7); #1;
        chk("cs_rdy", cmt_ready, 1'b1);
        tick(); idle_inputs();
        chk("cs_we", st_we, 1'b0);

        // 4: same-rd dispatch supersedes owning commit
        set_disp(5'd5, 6'd3);
        tick(); idle_inputs();
        set_disp(5'd5, 6'd4); set_cmt(5'd5, 6'd3); #1;
        chk("sr_drdy", disp_ready, 1'b1);
        chk("sr_crdy", cmt_ready, 1'b1);
        tick(); idle_inputs();
        chk("sr_we", st_we, 1'b1);
        chk("sr_idx", st_idx, 5'd5);
        chk("sr_data", st_data, 6'd4);

        // 5: conflict held three cycles, commit wins on the third
        set_disp(5'd9, 6'd6);
        tick(); idle_inputs();
        set_disp(5'd2, 6'd1); set_cmt(5'd9, 6'd6);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("st_drdy", disp_ready, (c < 2) ? 1'b1 : 1'b0);
            chk("st_crdy", cmt_ready, (c < 2) ? 1'b0 : 1'b1);
            tick();
            chk("st_idx", st_idx, (c < 2) ? 5'd2 : 5'd9);
            chk("st_data", st_data, (c < 2) ? 6'd1 : 6'h10);
        end
        idle_inputs();

        // rd0 and illegal tags are accepted without writing
        set_disp(5'd0, 6'd2); #1;
        chk("x0_rdy", disp_ready, 1'b1);
        tick(); idle_inputs();
        chk("x0_we", st_we, 1'b0);
        set_disp(5'd3, 6'd20); #1;
        chk("ill_rdy", disp_ready, 1'b1);
        tick(); idle_inputs();
        chk("ill_we", st_we, 1'b0);
        set_cmt(5'd4, 6'd17); #1;
        chk("illc_rdy", cmt_ready, 1'b1);
        tick(); idle_inputs();
        chk("illc_we", st_we, 1'b0);

        // 6: full flush; flush beats a same-cycle dispatch
        flush = 1'b1; set_disp(5'd6, 6'd1); #1;
        chk("fl_drdy", disp_ready, 1'b0);
        tick(); idle_inputs();
        chk("fl_busy0", flush_busy, 1'b1);
        chk("fl_we0", st_we, 1'b0);
        set_disp(5'd6, 6'd1); #1;
        chk("fl_drdy_busy", disp_ready, 1'b0);
        idle_inputs();
        for (int i = 0; i < NREG; i++) begin
            tick();
            chk("fl_we", st_we, 1'b1);
            chk("fl_idx", st_idx, i);
            chk("fl_data", st_data, 6'h10);
            chk("fl_busy", flush_busy, (i < NREG - 1) ? 1'b1 : 1'b0);
        end
        tick();
        chk("fl_done_we", st_we, 1'b0);
        chk("fl_tbl9", tbl[9], 6'h10);

        // reset in the middle of a flush returns straight to IDLE
        flush = 1'b1;
        tick(); flush = 1'b0;
        for (int i = 0; i <= 10; i++) tick();
        chk("mr_idx10", st_idx, 5'd10);
        rst = 1'b1; #1;
        chk("mr_we", st_we, 1'b0);
        chk("mr_busy", flush_busy, 1'b0);
        chk("mr_idx", st_idx, 5'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("mr_we2", st_we, 1'b0);
        set_disp(5'd7, 6'd2); #1;
        chk("mr_drdy", disp_ready, 1'b1);
        tick(); idle_inputs();
        chk("mr_idx2", st_idx, 5'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
